audio_tone_timer: RTL and testbench
===================================

AUDIO_TONE_TIMER -- requirements
Module: audio_tone_timer

Interface
REQ-001 The module SHALL have parameter TONE_DIV_1, default 20'd56818, meaning the half-period in clk cycles for sound_key 1 (shot).
REQ-002 The module SHALL have parameter TONE_DIV_2, default 20'd113636, meaning the half-period in clk cycles for sound_key 2 (player hit).
REQ-003 The module SHALL have parameter TONE_DIV_3, default 20'd85131, meaning the half-period in clk cycles for sound_key 3 (enemy dead).
REQ-004 The module SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 The module SHALL have port resetN, input, 1 bit: asynchronous active-low reset.
REQ-006 The module SHALL have port tick, input, 1 bit: one-clk-wide duration time-base strobe.
REQ-007 The module SHALL have port sound_key, input, 4 bits: selected sound; 1/2/3 are tones, any other value is silence.
REQ-008 The module SHALL have port request_time, input, 1 bit: a level sampled every clk that starts or restarts the duration timer.
REQ-009 The module SHALL have port time_amount, input, 11 bits: duration in tick periods, sampled when request_time=1.
REQ-010 The module SHALL have port time_done, output, 1 bit: one-clk pulse marking duration expiry; it drives the requester's slowClk.
REQ-011 The module SHALL have port busy, output, 1 bit: high while the timer is in RUN.
REQ-012 The module SHALL have port remaining, output, 11 bits: current duration count.
REQ-013 The module SHALL have port audio_out, output, 1 bit: square-wave audio output.

Function
REQ-014 The timer state machine SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 In any state, request_time=1 with time_amount!=0 SHALL load remaining<=time_amount and move to RUN on the next clk; this restarts the timer with no time_done.
REQ-016 request_time=1 with time_amount=0 SHALL be ignored, leaving state, remaining and outputs unchanged.
REQ-017 In RUN with no valid load, each tick=1 SHALL decrement remaining by 1.
REQ-018 In RUN, a tick when remaining=1 SHALL set remaining<=0 and move to DONE.
REQ-019 DONE SHALL last exactly one clk, with time_done=1, then move to IDLE unless a load occurs in that cycle.
REQ-020 Latency SHALL be exactly N tick strobes plus 1 clk: time_done is asserted in the cycle after the Nth tick counted in RUN, where N=time_amount.
REQ-021 A tick in the same clk as a valid load SHALL NOT be counted, because the load has priority.
REQ-022 A tick SHALL have no effect in IDLE or DONE.
REQ-023 busy SHALL equal (state==RUN), and time_done SHALL equal (state==DONE); both SHALL be registered-state decodes with no combinational path from the inputs.
REQ-024 The tone half-period SHALL be TONE_DIV_k when sound_key=k for k in {1,2,3}.
REQ-025 The tone generator SHALL use a 20-bit divider counter that, while in RUN with a tone key, increments each clk; on reaching half-period-1 it wraps to 0 and toggles audio_out.
REQ-026 When sound_key differs from its value registered on the previous clk, the divider SHALL be cleared to 0 and audio_out SHALL be cleared to 0 on that clk.
REQ-027 When not in RUN, or when sound_key is not in {1,2,3}, the divider and audio_out SHALL be held at 0.
REQ-028 A restart load while in RUN SHALL NOT clear the divider if sound_key is unchanged, so the tone phase stays continuous.
REQ-029 remaining SHALL never underflow below 0 and SHALL never wrap.

Reset
REQ-030 While resetN=0, and asynchronously on its falling edge, the module SHALL force state=IDLE, remaining=0, time_done=0, busy=0, audio_out=0, divider=0 and the registered previous sound_key=15.
REQ-031 Reset asserted mid-RUN SHALL abort with no time_done pulse; after release the module SHALL sit in IDLE until the next valid load.

Verification
REQ-032 The bench SHALL check: one-clk request_time with time_amount=5, then 5 ticks spaced 10 clk apart -> busy=1 from the clk after the load, remaining 5->4->3->2->1->0, time_done=1 for exactly one clk after the 5th tick, then busy=0.
REQ-033 The bench SHALL check: TONE_DIV_1 overridden to 4, sound_key=1, timer running -> audio_out toggles every 4 clk (period 8 clk) starting at 0; changing sound_key to 15 -> audio_out=0 on the next clk.
REQ-034 The bench SHALL check: reload with time_amount=3 mid-run at remaining=2 -> remaining=3, no time_done, expiry 3 ticks later.
REQ-035 The bench SHALL check: request_time with time_amount=0 in IDLE -> busy stays 0, time_done never asserts, remaining=0.
REQ-036 The bench SHALL check: tick and valid load (time_amount=2) in the same clk -> remaining=2 (tick not counted), and time_done after 2 further ticks.
REQ-037 The bench SHALL check: resetN pulsed low at remaining=4 with audio_out=1 -> all outputs 0 immediately, no time_done after release, IDLE held with ticks applied.

Source files
------------

// File: rtl/audio_tone_timer.sv
// Duration timer (IDLE/RUN/DONE) counting tick strobes, plus a square-wave tone
// generator that only sounds while the timer is running.
module audio_tone_timer #(
   parameter logic [19:0] TONE_DIV_1 = 20'd56818,
   parameter logic [19:0] TONE_DIV_2 = 20'd113636,
   parameter logic [19:0] TONE_DIV_3 = 20'd85131
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        tick,
   input  logic [3:0]  sound_key,
   input  logic        request_time,
   input  logic [10:0] time_amount,
   output logic        time_done,
   output logic        busy,
   output logic [10:0] remaining,
   output logic        audio_out
);

   // state | meaning
   // IDLE  | waiting for a non-zero load
   // RUN   | counting ticks down from time_amount
   // DONE  | single-clk expiry pulse on time_done
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [10:0] remaining_q, remaining_d;
   logic [19:0] div_q, div_d;
   logic        audio_q, audio_d;
   logic [3:0]  key_prev_q, key_prev_d;

   logic        load;
   logic [19:0] half_period;
   logic        tone_valid;

   assign load = request_time && (time_amount != 11'd0);

   always_comb begin
      half_period = 20'd0;
      tone_valid  = 1'b0;
      case (sound_key)
         4'd1: begin half_period = TONE_DIV_1; tone_valid = 1'b1; end
         4'd2: begin half_period = TONE_DIV_2; tone_valid = 1'b1; end
         4'd3: begin half_period = TONE_DIV_3; tone_valid = 1'b1; end
         default: ;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      if (load) begin
         state_d     = RUN;
         remaining_d = time_amount;
      end else begin
         case (state_q)
            RUN: begin
               if (tick) begin
                  // remaining<=1 also covers 0 so the count can never wrap
                  if (remaining_q <= 11'd1) begin
                     remaining_d = 11'd0;
                     state_d     = DONE;
                  end else begin
                     remaining_d = remaining_q - 11'd1;
                  end
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // A restart load keeps state_q at RUN, so the divider phase is preserved.
   always_comb begin
      div_d      = div_q;
      audio_d    = audio_q;
      key_prev_d = sound_key;
      if (sound_key != key_prev_q) begin
         div_d   = 20'd0;
         audio_d = 1'b0;
      end else if ((state_q != RUN) || !tone_valid) begin
         div_d   = 20'd0;
         audio_d = 1'b0;
      end else if (div_q == (half_period - 20'd1)) begin
         div_d   = 20'd0;
         audio_d = ~audio_q;
      end else begin
         div_d = div_q + 20'd1;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q     <= IDLE;
         remaining_q <= 11'd0;
         div_q       <= 20'd0;
         audio_q     <= 1'b0;
         key_prev_q  <= 4'd15;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         div_q       <= div_d;
         audio_q     <= audio_d;
         key_prev_q  <= key_prev_d;
      end
   end

   assign busy      = (state_q == RUN);
   assign time_done = (state_q == DONE);
   assign remaining = remaining_q;
   assign audio_out = audio_q;

endmodule

// File: tb/tb_audio_tone_timer.sv
// Self-checking bench for audio_tone_timer: directed scenarios followed by
// random stimulus, all compared against a cycle-level behavioural model.
module tb_audio_tone_timer;

   localparam int DIV1 = 4;
   localparam int DIV2 = 6;
   localparam int DIV3 = 5;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        tick = 1'b0;
   logic [3:0]  sound_key = 4'd0;
   logic        request_time = 1'b0;
   logic [10:0] time_amount = 11'd0;
   logic        time_done;
   logic        busy;
   logic [10:0] remaining;
   logic        audio_out;

   audio_tone_timer #(
      .TONE_DIV_1(20'(DIV1)),
      .TONE_DIV_2(20'(DIV2)),
      .TONE_DIV_3(20'(DIV3))
   ) dut (
      .clk(clk),
      .resetN(resetN),
      .tick(tick),
      .sound_key(sound_key),
      .request_time(request_time),
      .time_amount(time_amount),
      .time_done(time_done),
      .busy(busy),
      .remaining(remaining),
      .audio_out(audio_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // reference model state
   int m_rem;
   int m_run;
   int m_done;
   int m_prev;
   int m_age;
   int m_audio;

   task automatic chk(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int half_of(input int k);
      case (k)
         1: return DIV1;
         2: return DIV2;
         3: return DIV3;
         default: return 0;
      endcase
   endfunction

   function automatic void model_reset();
      m_rem = 0; m_run = 0; m_done = 0; m_prev = 15; m_age = 0; m_audio = 0;
   endfunction

   // One clock edge of the model; age counts consecutive clocks of steady tone.
   function automatic void model_edge();
      int h;
      int key;
      bit ld;
      key = int'(sound_key);
      h   = half_of(key);
      ld  = request_time && (time_amount != 0);
      if (key != m_prev) m_age = 0;
      else if (m_run != 0 && h != 0) m_age++;
      else m_age = 0;
      m_audio = (m_age == 0) ? 0 : ((m_age / h) % 2);
      m_prev  = key;
      if (ld) begin
         m_rem = int'(time_amount); m_run = 1; m_done = 0;
      end else if (m_run != 0) begin
         if (tick) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin m_run = 0; m_done = 1; end
         end
      end else begin
         m_done = 0;
      end
   endfunction

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("busy", busy, m_run);
      chk("time_done", time_done, m_done);
      chk("remaining", remaining, m_rem);
      chk("audio_out", audio_out, m_audio);
   endtask

   task automatic cyc(input bit t, input bit r, input int amt);
      tick = t;
      request_time = r;
      time_amount = 11'(amt);
      step();
      tick = 1'b0;
      request_time = 1'b0;
      time_amount = 11'd0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0);
   endtask

   initial begin
      model_reset();
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", time_done, 0);
      chk("rst_remaining", remaining, 0);
      chk("rst_audio", audio_out, 0);
      @(negedge clk);
      resetN = 1'b1;
      @(posedge clk);
      #1;
      model_edge();
      chk("idle_busy", busy, 0);

      // basic 5-tick countdown
      sound_key = 4'd0;
      cyc(0, 1, 5);
      chk("load5_busy", busy, 1);
      chk("load5_rem", remaining, 5);
      for (int k = 1; k <= 5; k++) begin
         idle(9);
         cyc(1, 0, 0);
         chk("count_rem", remaining, 5 - k);
         if (k < 5) chk("count_busy", busy, 1);
      end
      chk("expire_done", time_done, 1);
      chk("expire_busy", busy, 0);
      cyc(0, 0, 0);
      chk("post_done", time_done, 0);
      chk("post_busy", busy, 0);

      // tone: half-period 4
      sound_key = 4'd1;
      cyc(0, 1, 200);
      chk("tone_start", audio_out, 0);
      for (int i = 1; i <= 20; i++) begin
         cyc(0, 0, 0);
         chk("tone_wave", audio_out, (i / 4) % 2);
      end
      sound_key = 4'd15;
      cyc(0, 0, 0);
      chk("tone_silence", audio_out, 0);

      // reload mid-run at remaining=2
      sound_key = 4'd0;
      cyc(0, 1, 4);
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      chk("pre_reload_rem", remaining, 2);
      cyc(0, 1, 3);
      chk("reload_rem", remaining, 3);
      chk("reload_nodone", time_done, 0);
      for (int k = 1; k <= 3; k++) begin
         idle(2);
         cyc(1, 0, 0);
      end
      chk("reload_expire", time_done, 1);
      cyc(0, 0, 0);

      // zero-length request ignored in IDLE
      cyc(0, 1, 0);
      chk("zero_busy", busy, 0);
      chk("zero_rem", remaining, 0);
      for (int i = 0; i < 4; i++) begin
         cyc(1, 0, 0);
         chk("zero_nodone", time_done, 0);
      end

      // tick coincident with load is not counted
      cyc(1, 1, 2);
      chk("tickload_rem", remaining, 2);
      cyc(1, 0, 0);
      chk("tickload_rem1", remaining, 1);
      cyc(1, 0, 0);
      chk("tickload_done", time_done, 1);
      cyc(0, 0, 0);

      // reset mid-run with audio high
      sound_key = 4'd2;
      cyc(0, 1, 6);
      idle(6);
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      chk("prerst_rem", remaining, 4);
      chk("prerst_audio", audio_out, 1);
      #3;
      resetN = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_done", time_done, 0);
      chk("arst_rem", remaining, 0);
      chk("arst_audio", audio_out, 0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      resetN = 1'b1;
      @(posedge clk);
      #1;
      model_edge();
      for (int i = 0; i < 6; i++) begin
         cyc(1, 0, 0);
         chk("postrst_busy", busy, 0);
         chk("postrst_done", time_done, 0);
      end

      // random stimulus against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 29) == 0) sound_key = 4'($urandom_range(0, 5) == 0 ? $urandom_range(0, 15) : $urandom_range(1, 3));
         cyc($urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 6));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
